uart_rx: RTL

- Serial-to-parallel UART receiver: 8N1-style frames in, bytes out through a valid/ready holding register.
- Sits directly upstream of the byte consumer (FIFO or control logic).
- Oversamples the asynchronous serial line with the system clock, samples mid-bit, shifts LSB first.
- Built from the team's standard primitives: counter, SIPO shift register and register styles.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_if.sv | 44 ++++
 rtl/uart_bit_timer.sv | 49 ++++
 rtl/uart_rx.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver/transmitter types and default constants
//
// Purpose: state encoding for the receiver FSM and the default bit timing
// shared by uart_rx and the future uart_tx.
// Ports: none (package).
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int DATA_BITS_DEF    = 8;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and byte handshake bundle of the UART receiver
//
// Purpose: groups the raw RX line, the valid/ready byte holding register and
// the error pulses into one bundle.
// Ports (signals):
//   serial_in      raw asynchronous RX line, idle high
//   data_out       received byte, stable while data_valid=1
//   data_valid     holding register full
//   data_ready     consumer accepts data_out on an edge with data_valid & data_ready
//   framing_error  one-cycle pulse: stop bit sampled low
//   overrun        one-cycle pulse: completed byte dropped, holding register full
// Modports: master = receiver side, slave = line driver / byte consumer side.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
) ();

  logic                 serial_in;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 framing_error;
  logic                 overrun;

  modport master (
    input  serial_in,
    input  data_ready,
    output data_out,
    output data_valid,
    output framing_error,
    output overrun
  );

  modport slave (
    output serial_in,
    output data_ready,
    input  data_out,
    input  data_valid,
    input  framing_error,
    input  overrun
  );

endinterface

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period counter with half-bit and full-bit ticks
//
// Purpose: counts system clocks inside one serial bit. The counter only
// advances while enabled and only returns to zero through clear, so the
// owner decides exactly when a new bit period starts.
// Ports:
//   clock      system clock
//   reset_L    asynchronous active-low reset
//   clear      force counter to 0 on the next edge (has priority over enable)
//   enable     advance the counter by one
//   half_tick  counter is on the last clock of half a bit period
//   full_tick  counter is on the last clock of a full bit period
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic clock,
  input  logic reset_L,
  input  logic clear,
  input  logic enable,
  output logic half_tick,
  output logic full_tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign half_tick = enable && (cnt_q == CNT_W'(CLKS_PER_BIT / 2 - 1));
  assign full_tick = enable && (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8N1-style UART receiver with valid/ready byte output
//
// Purpose: synchronises the raw RX line, finds the start edge, samples each
// bit in its middle, shifts LSB first and hands the byte to a one-entry
// valid/ready holding register. Bad stop bits and dropped bytes are reported
// as single-cycle pulses.
// Ports:
//   clock    system clock, all logic on posedge
//   reset_L  asynchronous active-low reset
//   rx_if    uart_rx_if.master: serial_in, data_ready in;
//            data_out, data_valid, framing_error, overrun out
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic      clock,
  input  logic      reset_L,
  uart_rx_if.master rx_if
);

  localparam int IDX_W = $clog2(DATA_BITS);

  rx_state_t            state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 rx_prev_q, rx_prev_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 framing_error_q, framing_error_d;
  logic                 overrun_q, overrun_d;

  logic rx_s;
  logic timer_clear;
  logic timer_enable;
  logic half_tick;
  logic full_tick;

  assign rx_s = sync2_q;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clock     (clock),
    .reset_L   (reset_L),
    .clear     (timer_clear),
    .enable    (timer_enable),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  // State register
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      // Only a high-to-low transition starts a frame, so a line parked low
      // after a framing error stays idle until it has gone high again.
      IDLE:  if (!rx_s && rx_prev_q) state_d = START;
      START: if (half_tick) state_d = rx_s ? IDLE : DATA;
      DATA:  if (full_tick && (bit_idx_q == IDX_W'(DATA_BITS - 1))) state_d = STOP;
      // Leaving at mid-stop-bit leaves half a bit to catch the next start edge.
      STOP:  if (full_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath logic
  always_comb begin
    sync1_d         = rx_if.serial_in;
    sync2_d         = sync1_q;
    rx_prev_d       = sync2_q;
    timer_clear     = 1'b0;
    timer_enable    = (state_q != IDLE);
    bit_idx_d       = bit_idx_q;
    shift_d         = shift_q;
    data_out_d      = data_out_q;
    data_valid_d    = data_valid_q;
    framing_error_d = 1'b0;
    overrun_d       = 1'b0;

    if (data_valid_q && rx_if.data_ready) begin
      data_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        timer_clear = 1'b1;
      end
      START: begin
        if (half_tick) begin
          timer_clear = 1'b1;
          bit_idx_d   = '0;
        end
      end
      DATA: begin
        if (full_tick) begin
          timer_clear = 1'b1;
          shift_d     = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_idx_d   = bit_idx_q + IDX_W'(1);
        end
      end
      STOP: begin
        if (full_tick) begin
          timer_clear = 1'b1;
          if (!rx_s) begin
            framing_error_d = 1'b1;
          end else if (!data_valid_q || rx_if.data_ready) begin
            // An accept on this same edge frees the register for the new byte.
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      default: begin
        timer_clear = 1'b1;
      end
    endcase
  end

  // Datapath registers; the synchroniser resets to the idle line level.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      sync1_q         <= 1'b1;
      sync2_q         <= 1'b1;
      rx_prev_q       <= 1'b1;
      bit_idx_q       <= '0;
      shift_q         <= '0;
      data_out_q      <= '0;
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      rx_prev_q       <= rx_prev_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      data_out_q      <= data_out_d;
      data_valid_q    <= data_valid_d;
      framing_error_q <= framing_error_d;
      overrun_q       <= overrun_d;
    end
  end

  assign rx_if.data_out      = data_out_q;
  assign rx_if.data_valid    = data_valid_q;
  assign rx_if.framing_error = framing_error_q;
  assign rx_if.overrun       = overrun_q;

endmodule
